// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: one SLICE-bit piece per clock, LSB first.
// Produces x86-style CF/OF/SF/ZF with a start/busy/done handshake.
module addsub_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cf,
    output logic             of,
    output logic             sf,
    output logic             zf
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             c_q;
    logic             sub_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cf_q;
    logic             of_q;
    logic             sf_q;
    logic             zf_q;

    logic [SLICE:0]   sl_full;
    logic [WIDTH-1:0] sl_ext;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic             cmsb;
    logic             last;
    logic             c0;

    // Operands shift right so the active slice always sits in the low bits.
    always_comb begin
        sl_full = {1'b0, a_q[SLICE-1:0]}
                + {1'b0, b_q[SLICE-1:0]}
                + {{SLICE{1'b0}}, c_q};
        cmsb    = sl_full[SLICE-1] ^ a_q[SLICE-1] ^ b_q[SLICE-1];
        sl_ext  = '0;
        sl_ext[SLICE-1:0] = sl_full[SLICE-1:0];
        res_d   = (res_q >> SLICE) | (sl_ext << (WIDTH - SLICE));
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        last    = (k_q == KW'(NSLICE - 1));
        c0      = op[1] ? (cin ^ op[0]) : op[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        k_q     <= '0;
                        a_q     <= a;
                        b_q     <= op[0] ? ~b : b;
                        c_q     <= c0;
                        sub_q   <= op[0];
                        res_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    c_q   <= sl_full[SLICE];
                    res_q <= res_d;
                    if (last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cf_q    <= sl_full[SLICE] ^ sub_q;
                        of_q    <= sl_full[SLICE] ^ cmsb;
                        sf_q    <= res_d[WIDTH-1];
                        zf_q    <= (res_d == '0);
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cf   = cf_q;
    assign of   = of_q;
    assign sf   = sf_q;
    assign zf   = zf_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed and sweep bench for addsub_multicycle at three parameter sets.
// Flags are compared as {cf, of, sf, zf}.
module tb_addsub_multicycle;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 0, cin0 = 0;
    logic [31:0] a0 = 0, b0 = 0;
    logic [1:0]  op0 = 0;
    logic        busy0, done0, cf0, of0, sf0, zf0;
    logic [31:0] sum0;

    logic        start1 = 0, cin1 = 0;
    logic [15:0] a1 = 0, b1 = 0;
    logic [1:0]  op1 = 0;
    logic        busy1, done1, cf1, of1, sf1, zf1;
    logic [15:0] sum1;

    logic        start2 = 0, cin2 = 0;
    logic [63:0] a2 = 0, b2 = 0;
    logic [1:0]  op2 = 0;
    logic        busy2, done2, cf2, of2, sf2, zf2;
    logic [63:0] sum2;

    int checks = 0;
    int failures = 0;

    addsub_multicycle #(.WIDTH(32), .SLICE(8)) u0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
        .op(op0), .cin(cin0), .busy(busy0), .done(done0), .sum(sum0),
        .cf(cf0), .of(of0), .sf(sf0), .zf(zf0)
    );

    addsub_multicycle #(.WIDTH(16), .SLICE(16)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .op(op1), .cin(cin1), .busy(busy1), .done(done1), .sum(sum1),
        .cf(cf1), .of(of1), .sf(sf1), .zf(zf1)
    );

    addsub_multicycle #(.WIDTH(64), .SLICE(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .op(op2), .cin(cin2), .busy(busy2), .done(done2), .sum(sum2),
        .cf(cf2), .of(of2), .sf(sf2), .zf(zf2)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic [3:0]  f;
    } vec_t;

    // Reference built from plain wide arithmetic and sign rules.
    function automatic void model(input int w, input logic [1:0] op,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, output logic [63:0] s,
                                  output logic [3:0] fl);
        logic [65:0] ua, ub, r, ci;
        logic [63:0] m;
        logic c, o, sa, sb, ss;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ci = {65'd0, op[1] & cin};
        ua = {2'b00, a};
        ub = {2'b00, b};
        if (!op[0]) begin
            r = ua + ub + ci;
            c = r[w];
        end else begin
            r = ua - ub - ci;
            c = (ua < ub + ci);
        end
        s  = r[63:0] & m;
        sa = a[w-1];
        sb = b[w-1];
        ss = s[w-1];
        o  = op[0] ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
        fl = {c, o, ss, (s == 64'd0)};
    endfunction

    task automatic run0(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin,
                        output int lat, output int bcnt);
        @(negedge clk);
        start0 = 1; op0 = op; a0 = a; b0 = b; cin0 = cin;
        @(negedge clk);
        start0 = 0;
        a0 = $urandom; b0 = $urandom; op0 = 2'($urandom); cin0 = 1'($urandom);
        lat = 0;
        bcnt = 0;
        while (done0 !== 1'b1 && lat < 40) begin
            if (busy0 === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({busy0, done0, sum0, cf0, of0, sf0, zf0} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%h f=%b%b%b%b want all 0",
                     busy0, done0, sum0, cf0, of0, sf0, zf0);
        end
        checks++;
        if ({busy1, done1, busy2, done2} !== 4'd0) begin
            failures++;
            $display("FAIL reset_other got %b want 0000", {busy1, done1, busy2, done2});
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        vec_t v [12];
        int lat, bcnt;
        logic [31:0] hold;
        v[0]  = '{2'b00, 32'd16,        32'd12,        1'b0, 32'd28,        4'b0000};
        v[1]  = '{2'b01, 32'd16,        32'd12,        1'b0, 32'd4,         4'b0000};
        v[2]  = '{2'b00, 32'h7fffffff,  32'd2,         1'b0, 32'h80000001,  4'b0110};
        v[3]  = '{2'b00, 32'hffffffff,  32'd1,         1'b0, 32'd0,         4'b1001};
        v[4]  = '{2'b01, 32'h16,        32'h17,        1'b0, 32'hffffffff,  4'b1010};
        v[5]  = '{2'b01, 32'h80000000,  32'd1,         1'b0, 32'h7fffffff,  4'b0100};
        v[6]  = '{2'b10, 32'd0,         32'd0,         1'b1, 32'd1,         4'b0000};
        v[7]  = '{2'b11, 32'd0,         32'd0,         1'b1, 32'hffffffff,  4'b1010};
        v[8]  = '{2'b00, 32'd5,         32'd3,         1'b1, 32'd8,         4'b0000};
        v[9]  = '{2'b01, 32'd5,         32'd3,         1'b1, 32'd2,         4'b0000};
        v[10] = '{2'b10, 32'hffffffff,  32'd0,         1'b1, 32'd0,         4'b1001};
        v[11] = '{2'b11, 32'd5,         32'd5,         1'b0, 32'd0,         4'b0001};
        for (int i = 0; i < 12; i++) begin
            run0(v[i].op, v[i].a, v[i].b, v[i].cin, lat, bcnt);
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL vec%0d_latency got %0d want 4", i, lat);
            end
            checks++;
            if (bcnt !== 4) begin
                failures++;
                $display("FAIL vec%0d_busy_cycles got %0d want 4", i, bcnt);
            end
            checks++;
            if (sum0 !== v[i].s) begin
                failures++;
                $display("FAIL vec%0d_sum got %h want %h", i, sum0, v[i].s);
            end
            checks++;
            if ({cf0, of0, sf0, zf0} !== v[i].f) begin
                failures++;
                $display("FAIL vec%0d_flags got %b want %b", i, {cf0, of0, sf0, zf0}, v[i].f);
            end
            hold = sum0;
            @(negedge clk);
            checks++;
            if ({done0, busy0} !== 2'b00 || sum0 !== hold) begin
                failures++;
                $display("FAIL vec%0d_after_done got done=%b busy=%b sum=%h want 0 0 %h",
                         i, done0, busy0, sum0, hold);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, dcnt;
        @(negedge clk);
        start0 = 1; op0 = 2'b00; a0 = 32'd100; b0 = 32'd23; cin0 = 0;
        @(negedge clk);
        start0 = 0;
        lat = 0;
        dcnt = 0;
        while (done0 !== 1'b1 && lat < 40) begin
            if (lat == 1) begin
                checks++;
                if (sum0 !== 32'd0) begin
                    failures++;
                    $display("FAIL hold_during_run got %h want 00000000", sum0);
                end
                start0 = 1; op0 = 2'b01; a0 = 32'd7; b0 = 32'd9;
            end else begin
                start0 = 0;
            end
            @(negedge clk);
            lat++;
        end
        start0 = 0;
        checks++;
        if (lat !== 4 || sum0 !== 32'd123) begin
            failures++;
            $display("FAIL ignore_start got lat=%0d sum=%h want 4 0000007b", lat, sum0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt !== 0) begin
            failures++;
            $display("FAIL ignore_not_queued got %0d active cycles want 0", dcnt);
        end
    endtask

    task automatic test_back_to_back();
        int last_d, nd, bad_busy;
        @(negedge clk);
        start0 = 1; op0 = 2'b00; a0 = 32'd1; b0 = 32'd2; cin0 = 0;
        last_d = -1;
        nd = 0;
        bad_busy = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 29) start0 = 0;
            if (done0 === 1'b1) begin
                nd++;
                checks++;
                if ((last_d < 0 && n != 4) || (last_d >= 0 && n - last_d != 5)) begin
                    failures++;
                    $display("FAIL b2b_spacing got done at %0d prev %0d want period 5", n, last_d);
                end
                checks++;
                if (sum0 !== 32'd3) begin
                    failures++;
                    $display("FAIL b2b_sum got %h want 00000003", sum0);
                end
                last_d = n;
            end
            if (busy0 === done0) bad_busy++;
        end
        checks++;
        if (nd !== 6 || bad_busy !== 0) begin
            failures++;
            $display("FAIL b2b_count got dones=%0d busy_errs=%0d want 6 0", nd, bad_busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int lat, bcnt, dcnt;
        run0(2'b00, 32'hffffffff, 32'hffffffff, 1'b0, lat, bcnt);
        checks++;
        if (sum0 !== 32'hfffffffe || {cf0, of0, sf0, zf0} !== 4'b1010) begin
            failures++;
            $display("FAIL pre_reset_op got %h %b want fffffffe 1010",
                     sum0, {cf0, of0, sf0, zf0});
        end
        @(negedge clk);
        start0 = 1; op0 = 2'b00; a0 = 32'd9; b0 = 32'd9;
        @(negedge clk);
        start0 = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if ({busy0, done0, sum0, cf0, of0, sf0, zf0} !== 38'd0) begin
            failures++;
            $display("FAIL reset_midrun got busy=%b done=%b sum=%h f=%b%b%b%b want all 0",
                     busy0, done0, sum0, cf0, of0, sf0, zf0);
        end
        @(negedge clk);
        rst = 0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) dcnt++;
        end
        checks++;
        if (dcnt !== 0 || sum0 !== 32'd0) begin
            failures++;
            $display("FAIL no_done_after_abort got active=%0d sum=%h want 0 0", dcnt, sum0);
        end
    endtask

    task automatic test_sweep(input int sel);
        int w, ns, lat;
        logic [63:0] m, ra, rb, es, gs;
        logic [3:0] ef, gf;
        logic ci;
        w  = (sel != 0) ? 64 : 16;
        ns = (sel != 0) ? 16 : 1;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        for (int md = 0; md < 4; md++) begin
            for (int i = 0; i < 100; i++) begin
                ra = {$urandom, $urandom} & m;
                rb = {$urandom, $urandom} & m;
                if (i % 10 == 0) rb = ra;
                if (i % 10 == 1) ra = m;
                ci = 1'($urandom);
                model(w, 2'(md), ra, rb, ci, es, ef);
                @(negedge clk);
                if (sel != 0) begin
                    start2 = 1; op2 = 2'(md); a2 = ra; b2 = rb; cin2 = ci;
                end else begin
                    start1 = 1; op1 = 2'(md); a1 = ra[15:0]; b1 = rb[15:0]; cin1 = ci;
                end
                @(negedge clk);
                start1 = 0;
                start2 = 0;
                lat = 0;
                while (((sel != 0) ? done2 : done1) !== 1'b1 && lat < 60) begin
                    @(negedge clk);
                    lat++;
                end
                gs = (sel != 0) ? sum2 : {48'd0, sum1};
                gf = (sel != 0) ? {cf2, of2, sf2, zf2} : {cf1, of1, sf1, zf1};
                checks++;
                if (lat !== ns) begin
                    failures++;
                    $display("FAIL sweep%0d_latency got %0d want %0d", w, lat, ns);
                end
                checks++;
                if (gs !== es) begin
                    failures++;
                    $display("FAIL sweep%0d_sum op=%0d a=%h b=%h cin=%b got %h want %h",
                             w, md, ra, rb, ci, gs, es);
                end
                checks++;
                if (gf !== ef) begin
                    failures++;
                    $display("FAIL sweep%0d_flags op=%0d a=%h b=%h cin=%b got %b want %b",
                             w, md, ra, rb, ci, gf, ef);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_sweep(0);
        test_sweep(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
